dcim_result_collector: RTL
==========================

DCIM_RESULT_COLLECTOR -- requirements
Module: dcim_result_collector

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, operand width of the DCIM multiplier.
REQ-002 SHALL have parameter ADDR_COUNT, default 16, results per frame (= SRAM weight entries).
REQ-003 SHALL have parameter ADDR_WIDTH, default 4, log2(ADDR_COUNT).
REQ-004 SHALL derive MULT_WIDTH = 2*DATA_WIDTH (16) and ACC_WIDTH = MULT_WIDTH+ADDR_WIDTH (20).
REQ-005 SHALL have port clk  in  1  clock; all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, synchronous, active-low.
REQ-007 SHALL have port arm  in  1  start collecting one frame (sampled in IDLE only).
REQ-008 SHALL have port clear  in  1  synchronous abort to IDLE.
REQ-009 SHALL have port res_valid  in  1  multiplier result strobe (from sram_multiplier_system valid_out).
REQ-010 SHALL have port res_data  in  MULT_WIDTH  multiplier product (from data_out).
REQ-011 SHALL have port out_valid  out  1  drain beat available.
REQ-012 SHALL have port out_ready  in  1  downstream accepts beat.
REQ-013 SHALL have port out_data  out  MULT_WIDTH  buffered result at read pointer.
REQ-014 SHALL have port out_last  out  1  high with out_valid on entry ADDR_COUNT-1.
REQ-015 SHALL have port frame_sum  out  ACC_WIDTH  sum of all products of current/last frame.
REQ-016 SHALL have port frame_done  out  1  one-cycle pulse on final accepted drain beat.
REQ-017 SHALL have port drop_err  out  1  sticky: result arrived while not in COLLECT after arm.

Function
REQ-018 SHALL implement FSM states IDLE, COLLECT, DRAIN.
REQ-019 IDLE: arm=1 -> COLLECT; wr_ptr, rd_ptr, frame_sum cleared on that transition.
REQ-020 COLLECT: each cycle res_valid=1 writes res_data to buffer[wr_ptr], wr_ptr+1, frame_sum += res_data (zero-extended).
REQ-021 COLLECT: capture with wr_ptr=ADDR_COUNT-1 -> DRAIN next cycle; wr_ptr wraps to 0.
REQ-022 DRAIN: out_valid=1, out_data=buffer[rd_ptr] combinationally from registered array; out_last=(rd_ptr==ADDR_COUNT-1).
REQ-023 DRAIN: out_valid&out_ready advances rd_ptr; out_data/out_last stable while out_ready=0.
REQ-024 DRAIN: accepted beat with out_last=1 -> frame_done pulse same cycle as acceptance is registered (next cycle high for exactly one cycle), rd_ptr wraps to 0, state -> IDLE.
REQ-025 First out_valid SHALL be the cycle after the 16th capture (1-cycle latency).
REQ-026 res_valid in DRAIN SHALL be discarded (no write, no sum update) and set drop_err; res_valid in IDLE is ignored silently.
REQ-027 frame_sum SHALL hold its final value through DRAIN and IDLE until next arm; no saturation needed (ACC_WIDTH cannot overflow: 16*65025 < 2^20).
REQ-028 clear SHALL take priority over arm, res_valid, out_ready: next state IDLE, pointers 0, frame_sum 0, drop_err 0, no frame_done.
REQ-029 arm asserted outside IDLE SHALL be ignored.

Reset
REQ-030 rst_n=0 at a rising edge SHALL force state IDLE, wr_ptr=0, rd_ptr=0, frame_sum=0, out_valid=0, out_last=0, frame_done=0, drop_err=0.
REQ-031 Reset mid-COLLECT or mid-DRAIN SHALL discard the partial frame; buffer contents need not be cleared.

Structure
REQ-032 Package dcim_pkg SHALL hold DATA_WIDTH, ADDR_COUNT, ADDR_WIDTH, MULT_WIDTH, ACC_WIDTH and the FSM state typedef.
REQ-033 Storage SHALL be sub-module dcim_result_buffer: ADDR_COUNT x MULT_WIDTH register file, 1 sync write port, 1 async read port, no reset.
REQ-034 FSM, pointers, accumulator SHALL live in dcim_result_collector.

Verification
REQ-035 Arm, res_data=1..16 on 16 consecutive cycles, out_ready=1 -> out_data 1..16 in order, out_last on 16, frame_sum=136, one frame_done, back to IDLE.
REQ-036 Gapped res_valid (every other cycle) with 16 values 65025 -> frame_sum=1040400, DRAIN entered only after 16th capture.
REQ-037 out_ready toggled 1/0 during DRAIN -> each value presented held until accepted, no skip/duplication, 16 accepted beats total.
REQ-038 res_valid=1 with value 500 during DRAIN -> drop_err=1, frame_sum unchanged, drained data unchanged.
REQ-039 clear after 7 captures -> IDLE next cycle, frame_sum=0, out_valid=0; re-arm and 16 values 2 -> frame_sum=32.
REQ-040 rst_n=0 for 2 cycles during DRAIN -> all outputs reset values; three back-to-back arm/collect/drain frames after reset each produce correct frame_sum.

Source files
------------

// File: rtl/dcim_pkg.sv
// Shared sizing constants and FSM state type for the DCIM result collector slice.
package dcim_pkg;

    localparam int DATA_WIDTH = 8;
    localparam int ADDR_COUNT = 16;
    localparam int ADDR_WIDTH = 4;
    localparam int MULT_WIDTH = 2 * DATA_WIDTH;
    localparam int ACC_WIDTH  = MULT_WIDTH + ADDR_WIDTH;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

endpackage

// File: rtl/dcim_result_buffer.sv
// Frame buffer for multiplier products: one synchronous write port, one asynchronous read port.
module dcim_result_buffer #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 16,
    parameter int AW    = 4
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // NOTE: storage has no reset; every entry is rewritten before it is drained, so a reset would only cost flops.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dcim_result_collector.sv
// Collects one frame of DCIM multiplier products, accumulates their sum, then drains them over a valid/ready port.
module dcim_result_collector #(
    parameter  int DATA_WIDTH = dcim_pkg::DATA_WIDTH,
    parameter  int ADDR_COUNT = dcim_pkg::ADDR_COUNT,
    parameter  int ADDR_WIDTH = dcim_pkg::ADDR_WIDTH,
    localparam int MULT_WIDTH = 2 * DATA_WIDTH,
    localparam int ACC_WIDTH  = MULT_WIDTH + ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arm,
    input  logic                  clear,
    input  logic                  res_valid,
    input  logic [MULT_WIDTH-1:0] res_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [MULT_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic [ACC_WIDTH-1:0]  frame_sum,
    output logic                  frame_done,
    output logic                  drop_err
);

    import dcim_pkg::state_t;
    import dcim_pkg::IDLE;
    import dcim_pkg::COLLECT;
    import dcim_pkg::DRAIN;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(ADDR_COUNT - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic                  wr_en;

    // Writes are gated by the same conditions that advance wr_ptr and the sum.
    assign wr_en     = rst_n && !clear && (state == COLLECT) && res_valid;
    assign out_valid = (state == DRAIN);
    assign out_last  = out_valid && (rd_ptr == LAST_ADDR);

    dcim_result_buffer #(
        .DEPTH (ADDR_COUNT),
        .WIDTH (MULT_WIDTH),
        .AW    (ADDR_WIDTH)
    ) u_buffer (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_ptr),
        .wr_data (res_data),
        .rd_addr (rd_ptr),
        .rd_data (out_data)
    );

    // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            state      <= IDLE;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_sum  <= '0;
            frame_done <= 1'b0;
            drop_err   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (arm) begin
                        state     <= COLLECT;
                        wr_ptr    <= '0;
                        rd_ptr    <= '0;
                        frame_sum <= '0;
                    end
                end
                COLLECT: begin
                    if (res_valid) begin
                        frame_sum <= frame_sum + ACC_WIDTH'(res_data);
                        if (wr_ptr == LAST_ADDR) begin
                            wr_ptr <= '0;
                            state  <= DRAIN;
                        end else begin
                            wr_ptr <= wr_ptr + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (res_valid) begin
                        drop_err <= 1'b1;
                    end
                    if (out_ready) begin
                        if (rd_ptr == LAST_ADDR) begin
                            rd_ptr     <= '0;
                            frame_done <= 1'b1;
                            state      <= IDLE;
                        end else begin
                            rd_ptr <= rd_ptr + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
